ram_port_arbiter: RTL and testbench

//  Two-requester round-robin arbiter sharing the single-port 1024x32 data RAM.

---
 rtl/ram_port_arbiter.sv | 123 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of the single-port 1024x32 data RAM.
// Optional ownership locking is compiled in with `define RAM_ARB_LOCK_EN.
module ram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_b,
`ifdef RAM_ARB_LOCK_EN
  input  logic              lock_a,
  input  logic              lock_b,
`endif
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_rr_last;
  logic                r_ack_a;
  logic                r_ack_b;
  logic [DATA_W-1:0]   r_rdata_a;
  logic [DATA_W-1:0]   r_rdata_b;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic                r_ram_we;
  logic                w_elig_a;
  logic                w_elig_b;
  logic                w_lock_hold;
`ifdef RAM_ARB_LOCK_EN
  logic                w_own_a;
  logic                w_own_b;
`endif

  // r_rr_last: 0 = A won last, 1 = B won last. The grant holder is masked at
  // the edge that produces its ack, so its held request is not served twice.
  always_comb begin
    w_elig_a    = req_a & (r_state != GNT_A);
    w_elig_b    = req_b & (r_state != GNT_B);
    w_lock_hold = 1'b0;
`ifdef RAM_ARB_LOCK_EN
    w_own_a = lock_a & ((r_state == GNT_A) | r_ack_a);
    w_own_b = lock_b & ((r_state == GNT_B) | r_ack_b);
    if (w_own_a)
      w_elig_b = 1'b0;
    else if (w_own_b)
      w_elig_a = 1'b0;
    w_lock_hold = w_own_a | w_own_b;
`endif
    w_next = IDLE;
    if (w_elig_a && w_elig_b)
      w_next = r_rr_last ? GNT_A : GNT_B;
    else if (w_elig_a)
      w_next = GNT_A;
    else if (w_elig_b)
      w_next = GNT_B;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_rr_last   <= 1'b1;
      r_ack_a     <= 1'b0;
      r_ack_b     <= 1'b0;
      r_rdata_a   <= '0;
      r_rdata_b   <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ack_a <= (r_state == GNT_A);
      r_ack_b <= (r_state == GNT_B);
      if (r_state == GNT_A)
        r_rdata_a <= ram_rdata;
      if (r_state == GNT_B)
        r_rdata_b <= ram_rdata;
      // A locked owner keeps the round-robin pointer where it was.
      case (w_next)
        GNT_A: begin
          r_ram_addr  <= addr_a;
          r_ram_wdata <= wdata_a;
          r_ram_we    <= we_a;
          if (!w_lock_hold)
            r_rr_last <= 1'b0;
        end
        GNT_B: begin
          r_ram_addr  <= addr_b;
          r_ram_wdata <= wdata_b;
          r_ram_we    <= we_b;
          if (!w_lock_hold)
            r_rr_last <= 1'b1;
        end
        default: r_ram_we <= 1'b0;
      endcase
    end
  end

  assign ack_a     = r_ack_a;
  assign ack_b     = r_ack_b;
  assign rdata_a   = r_rdata_a;
  assign rdata_b   = r_rdata_b;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_we    = r_ram_we;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural negedge-write RAM.
// Lock scenario is included when RAM_ARB_LOCK_EN is defined.
module tb_ram_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_a, we_a, req_b, we_b;
  logic [9:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic        ack_a, ack_b;
  logic [31:0] rdata_a, rdata_b;
`ifdef RAM_ARB_LOCK_EN
  logic        lock_a, lock_b;
`endif
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] mem [0:1023];

  int total = 0;
  int bad   = 0;

  ram_port_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .rdata_b(rdata_b),
`ifdef RAM_ARB_LOCK_EN
    .lock_a(lock_a), .lock_b(lock_b),
`endif
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  always #5 CLK = ~CLK;

  // RAM model: cleared by RST, writes on negedge, combinational read.
  always @(negedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = mem[ram_addr];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit portB, input logic req, input logic we,
                               input logic [9:0] addr, input logic [31:0] wdata);
    if (!portB) begin
      req_a = req; we_a = we; addr_a = addr; wdata_a = wdata;
    end else begin
      req_b = req; we_b = we; addr_b = addr; wdata_b = wdata;
    end
  endtask

  task automatic applyReset;
    RST = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    tick;
    RST = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ack_a"}, {31'b0, ack_a}, 32'h0);
    checkOutput({tag, "_ack_b"}, {31'b0, ack_b}, 32'h0);
    checkOutput({tag, "_rdata_a"}, rdata_a, 32'h0);
    checkOutput({tag, "_rdata_b"}, rdata_b, 32'h0);
    checkOutput({tag, "_ram_we"}, {31'b0, ram_we}, 32'h0);
    checkOutput({tag, "_ram_addr"}, {22'b0, ram_addr}, 32'h0);
    checkOutput({tag, "_ram_wdata"}, ram_wdata, 32'h0);
  endtask

  initial begin
    int idxA, idxB, bGrantCycle, aAcks;
    RST = 1'b1;
`ifdef RAM_ARB_LOCK_EN
    lock_a = 1'b0;
    lock_b = 1'b0;
`endif
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    tick;
    tick;
    checkResetState("rst");
    RST = 1'b0;

    // 1: A write then read back address 5
    applyStimulus(0, 1, 1, 10'd5, 32'hDEADBEEF);
    tick;
    checkOutput("t1_we_grant", {31'b0, ram_we}, 32'h1);
    checkOutput("t1_addr", {22'b0, ram_addr}, 32'd5);
    checkOutput("t1_wdata", ram_wdata, 32'hDEADBEEF);
    checkOutput("t1_ack_early", {31'b0, ack_a}, 32'h0);
    tick;
    checkOutput("t1_ack_wr", {31'b0, ack_a}, 32'h1);
    checkOutput("t1_we_idle", {31'b0, ram_we}, 32'h0);
    applyStimulus(0, 1, 0, 10'd5, 32'h0);
    tick;
    checkOutput("t1_ack_gap", {31'b0, ack_a}, 32'h0);
    checkOutput("t1_we_rd", {31'b0, ram_we}, 32'h0);
    tick;
    checkOutput("t1_ack_rd", {31'b0, ack_a}, 32'h1);
    checkOutput("t1_rdata", rdata_a, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 0);
    tick;
    checkOutput("t1_ack_pulse", {31'b0, ack_a}, 32'h0);

    // 2: simultaneous requests after reset, A wins the first tie
    applyReset;
    applyStimulus(0, 1, 1, 10'd10, 32'h0000AAAA);
    applyStimulus(1, 1, 1, 10'd11, 32'h0000BBBB);
    tick;
    checkOutput("t2_first_addr", {22'b0, ram_addr}, 32'd10);
    tick;
    checkOutput("t2_second_addr", {22'b0, ram_addr}, 32'd11);
    checkOutput("t2_ack_a", {31'b0, ack_a}, 32'h1);
    checkOutput("t2_ack_b_early", {31'b0, ack_b}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    tick;
    checkOutput("t2_ack_b", {31'b0, ack_b}, 32'h1);
    checkOutput("t2_ack_a_pulse", {31'b0, ack_a}, 32'h0);
    checkOutput("t2_we_idle", {31'b0, ram_we}, 32'h0);
    applyStimulus(1, 0, 0, 0, 0);

    // 3: both ports streaming 8 writes each, strict alternation
    applyReset;
    idxA = 0;
    idxB = 0;
    applyStimulus(0, 1, 1, 10'd0, 32'd100);
    applyStimulus(1, 1, 1, 10'd20, 32'd200);
    for (int k = 0; k <= 16; k++) begin
      tick;
      if (k < 16) begin
        checkOutput($sformatf("t3_we_%0d", k), {31'b0, ram_we}, 32'h1);
        checkOutput($sformatf("t3_addr_%0d", k), {22'b0, ram_addr},
                    (k % 2 == 0) ? 32'(k / 2) : 32'(20 + k / 2));
        checkOutput($sformatf("t3_wdata_%0d", k), ram_wdata,
                    (k % 2 == 0) ? 32'(100 + k / 2) : 32'(200 + k / 2));
      end else begin
        checkOutput("t3_we_end", {31'b0, ram_we}, 32'h0);
      end
      checkOutput($sformatf("t3_ack_a_%0d", k), {31'b0, ack_a}, (k % 2 == 1) ? 32'h1 : 32'h0);
      checkOutput($sformatf("t3_ack_b_%0d", k), {31'b0, ack_b},
                  (k >= 2 && k % 2 == 0) ? 32'h1 : 32'h0);
      if (ack_a) begin
        idxA++;
        if (idxA < 8) applyStimulus(0, 1, 1, 10'(idxA), 32'(100 + idxA));
        else          applyStimulus(0, 0, 0, 0, 0);
      end
      if (ack_b) begin
        idxB++;
        if (idxB < 8) applyStimulus(1, 1, 1, 10'(20 + idxB), 32'(200 + idxB));
        else          applyStimulus(1, 0, 0, 0, 0);
      end
    end

    // 4: B reads the word A writes one cycle earlier
    applyReset;
    applyStimulus(0, 1, 1, 10'd1023, 32'h1);
    applyStimulus(1, 1, 0, 10'd1023, 32'h0);
    tick;
    checkOutput("t4_a_grant", {22'b0, ram_addr}, 32'd1023);
    checkOutput("t4_a_we", {31'b0, ram_we}, 32'h1);
    tick;
    checkOutput("t4_ack_a", {31'b0, ack_a}, 32'h1);
    checkOutput("t4_rdata_a", rdata_a, 32'h1);
    checkOutput("t4_b_we", {31'b0, ram_we}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    tick;
    checkOutput("t4_ack_b", {31'b0, ack_b}, 32'h1);
    checkOutput("t4_rdata_b", rdata_b, 32'h1);
    applyStimulus(1, 0, 0, 0, 0);
    tick;

    // 5: reset lands in the middle of a B write grant
    applyStimulus(1, 1, 1, 10'd7, 32'd77);
    tick;
    checkOutput("t5_b_we", {31'b0, ram_we}, 32'h1);
    RST = 1'b1;
    #2;
    checkResetState("t5_rst");
    applyStimulus(1, 0, 0, 0, 0);
    tick;
    RST = 1'b0;
    tick;
    checkOutput("t5_no_ack_b", {31'b0, ack_b}, 32'h0);
    checkOutput("t5_mem_dropped", mem[7], 32'h0);
    applyStimulus(0, 1, 1, 10'd7, 32'h55);
    tick;
    checkOutput("t5_a_addr", {22'b0, ram_addr}, 32'd7);
    tick;
    checkOutput("t5_ack_a", {31'b0, ack_a}, 32'h1);
    checkOutput("t5_rdata_a", rdata_a, 32'h55);
    applyStimulus(0, 0, 0, 0, 0);
    tick;

`ifdef RAM_ARB_LOCK_EN
    // 6: A holds a lock over three accesses while B waits
    applyReset;
    idxA = 0;
    aAcks = 0;
    bGrantCycle = -1;
    lock_a = 1'b1;
    applyStimulus(0, 1, 1, 10'd30, 32'd300);
    applyStimulus(1, 1, 1, 10'd40, 32'd400);
    for (int k = 0; k < 12; k++) begin
      tick;
      if (ram_we && ram_addr == 10'd40 && bGrantCycle < 0) begin
        bGrantCycle = k;
        checkOutput("t6_a_acks_before_b", 32'(aAcks), 32'd3);
      end
      if (ack_b) applyStimulus(1, 0, 0, 0, 0);
      if (ack_a) begin
        aAcks++;
        idxA++;
        if (idxA < 3) begin
          applyStimulus(0, 1, 1, 10'(30 + idxA), 32'(300 + idxA));
        end else begin
          applyStimulus(0, 0, 0, 0, 0);
          lock_a = 1'b0;
        end
      end
    end
    checkOutput("t6_b_grant_cycle", 32'(bGrantCycle), 32'd6);
    checkOutput("t6_mem_b", mem[40], 32'd400);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
